// File: rtl/slc3_mem_responder.sv
// SLC-3 memory responder: services Mem_OE/Mem_WE strobes against
// an internal word RAM plus one memory-mapped I/O word.
module slc3_mem_responder #(
   parameter int                ADDR_W  = 16,
   parameter int                DEPTH   = 4096,
   parameter int                RD_LAT  = 1,
   parameter int                WR_LAT  = 2,
   parameter logic [ADDR_W-1:0] IO_ADDR = 16'hFFFF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Mem_OE,
   input  logic              Mem_WE,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [15:0]       Data_from_CPU,
   input  logic [15:0]       Switches,
   output logic [15:0]       Data_to_CPU,
   output logic              Ready,
   output logic [15:0]       Hex_Out,
   output logic              Proto_Err
);

   localparam int MAXL   = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
   localparam int CNT_W  = $clog2(MAXL + 1);
   localparam int RAM_AW = $clog2(DEPTH);

   localparam logic [CNT_W-1:0] RD_LAT_C = CNT_W'(RD_LAT);
   localparam logic [CNT_W-1:0] WR_LAT_C = CNT_W'(WR_LAT);
   localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W+1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RD_HOLD,
      WR_WAIT,
      WR_HOLD
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_inc;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       wdata_q;
   logic [ADDR_W-1:0] acc_addr;
   logic [15:0]       acc_data;
   logic [RAM_AW-1:0] ram_idx;
   logic              in_ram;
   logic              is_io;
   logic [15:0]       rd_val;
   logic              load;
   logic              commit;

   logic [15:0] mem [DEPTH];

   // Access address/data: live inputs on the launch edge, latched copies afterwards
   always_comb begin
      acc_addr = (state == IDLE) ? ADDR : addr_q;
      acc_data = (state == IDLE) ? Data_from_CPU : wdata_q;
      cnt_inc  = cnt + 1'b1;
      in_ram   = {1'b0, acc_addr} < DEPTH_C;
      is_io    = (acc_addr == IO_ADDR);
      ram_idx  = acc_addr[RAM_AW-1:0];
      if (in_ram)
         rd_val = mem[ram_idx];
      else if (is_io)
         rd_val = Switches;
      else
         rd_val = 16'h0000;
      load   = ((state == IDLE) && Mem_OE && !Mem_WE && (RD_LAT == 1)) ||
               ((state == RD_WAIT) && Mem_OE && (cnt_inc == RD_LAT_C));
      commit = ((state == IDLE) && Mem_WE && (WR_LAT == 1)) ||
               ((state == WR_WAIT) && Mem_WE && (cnt_inc == WR_LAT_C));
   end

   // Word RAM: contents survive reset; a write lands only on its commit edge
   always_ff @(posedge Clk) begin
      if (commit && in_ram && !Reset)
         mem[ram_idx] <= acc_data;
   end

   // Access sequencer with registered read data, ready, I/O register and error pulse
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         cnt         <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         Data_to_CPU <= 16'h0000;
         Ready       <= 1'b0;
         Hex_Out     <= 16'h0000;
         Proto_Err   <= 1'b0;
      end else begin
         Proto_Err <= 1'b0;
         if (load)
            Data_to_CPU <= rd_val;
         if (commit && is_io)
            Hex_Out <= acc_data;
         unique case (state)
            IDLE: begin
               Ready <= 1'b0;
               if (Mem_WE) begin
                  addr_q    <= ADDR;
                  wdata_q   <= Data_from_CPU;
                  cnt       <= CNT_W'(1);
                  Proto_Err <= Mem_OE;
                  if (WR_LAT == 1) begin
                     state <= WR_HOLD;
                     Ready <= 1'b1;
                  end else begin
                     state <= WR_WAIT;
                  end
               end else if (Mem_OE) begin
                  addr_q <= ADDR;
                  cnt    <= CNT_W'(1);
                  if (RD_LAT == 1) begin
                     state <= RD_HOLD;
                     Ready <= 1'b1;
                  end else begin
                     state <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               if (!Mem_OE) begin
                  state     <= IDLE;
                  Proto_Err <= 1'b1;
               end else begin
                  Proto_Err <= Mem_WE;
                  cnt       <= cnt_inc;
                  if (load) begin
                     state <= RD_HOLD;
                     Ready <= 1'b1;
                  end
               end
            end
            RD_HOLD: begin
               Proto_Err <= Mem_WE;
               if (!Mem_OE) begin
                  state <= IDLE;
                  Ready <= 1'b0;
               end
            end
            WR_WAIT: begin
               if (!Mem_WE) begin
                  state     <= IDLE;
                  Proto_Err <= 1'b1;
               end else begin
                  Proto_Err <= Mem_OE;
                  cnt       <= cnt_inc;
                  if (commit) begin
                     state <= WR_HOLD;
                     Ready <= 1'b1;
                  end
               end
            end
            WR_HOLD: begin
               Proto_Err <= Mem_OE;
               if (!Mem_WE) begin
                  state <= IDLE;
                  Ready <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               Ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Directed bench for slc3_mem_responder: default instance (RD_LAT=1)
// plus a RD_LAT=3 instance sharing the same stimulus.
module tb_slc3_mem_responder;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Mem_OE = 1'b0;
   logic        Mem_WE = 1'b0;
   logic [15:0] ADDR = 16'h0;
   logic [15:0] Din = 16'h0;
   logic [15:0] Switches = 16'h0;

   logic [15:0] d1_data, d1_hex, d2_data, d2_hex;
   logic        d1_ready, d1_err, d2_ready, d2_err;

   int total = 0;
   int bad = 0;

   always #5 Clk = ~Clk;

   slc3_mem_responder dut1 (
      .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
      .ADDR(ADDR), .Data_from_CPU(Din), .Switches(Switches),
      .Data_to_CPU(d1_data), .Ready(d1_ready), .Hex_Out(d1_hex),
      .Proto_Err(d1_err)
   );

   slc3_mem_responder #(.RD_LAT(3)) dut2 (
      .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
      .ADDR(ADDR), .Data_from_CPU(Din), .Switches(Switches),
      .Data_to_CPU(d2_data), .Ready(d2_ready), .Hex_Out(d2_hex),
      .Proto_Err(d2_err)
   );

   task automatic cyc();
      @(negedge Clk);
   endtask

   task automatic test_reset();
      #1;
      total++;
      if (d1_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0000", d1_data); end
      total++;
      if (d1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", d1_ready); end
      total++;
      if (d1_hex !== 16'h0) begin bad++; $display("FAIL reset_hex got=%h exp=0000", d1_hex); end
      total++;
      if (d1_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", d1_err); end
      cyc();
      Reset = 1'b0;
      cyc();
   endtask

   task automatic test_write_read();
      Mem_WE = 1'b1; ADDR = 16'h0010; Din = 16'hBEEF;
      cyc();
      total++;
      if (d1_ready !== 1'b0) begin bad++; $display("FAIL wr_wait_ready got=%b exp=0", d1_ready); end
      cyc();
      total++;
      if (d1_ready !== 1'b1) begin bad++; $display("FAIL wr_commit_ready got=%b exp=1", d1_ready); end
      Mem_WE = 1'b0;
      cyc();
      total++;
      if (d1_ready !== 1'b0) begin bad++; $display("FAIL wr_drop_ready got=%b exp=0", d1_ready); end
      Mem_OE = 1'b1;
      cyc();
      total++;
      if (d1_data !== 16'hBEEF) begin bad++; $display("FAIL rd_data got=%h exp=beef", d1_data); end
      total++;
      if (d1_ready !== 1'b1) begin bad++; $display("FAIL rd_ready got=%b exp=1", d1_ready); end
      Mem_OE = 1'b0;
      cyc();
      total++;
      if (d1_ready !== 1'b0) begin bad++; $display("FAIL rd_drop_ready got=%b exp=0", d1_ready); end
      total++;
      if (d1_data !== 16'hBEEF) begin bad++; $display("FAIL rd_retain got=%h exp=beef", d1_data); end
   endtask

   task automatic test_io();
      Mem_WE = 1'b1; ADDR = 16'hFFFF; Din = 16'h1234;
      cyc();
      total++;
      if (d1_hex !== 16'h0000) begin bad++; $display("FAIL io_hex_early got=%h exp=0000", d1_hex); end
      cyc();
      total++;
      if (d1_hex !== 16'h1234) begin bad++; $display("FAIL io_hex got=%h exp=1234", d1_hex); end
      Mem_WE = 1'b0;
      cyc();
      Switches = 16'h00A5; Mem_OE = 1'b1;
      cyc();
      total++;
      if (d1_data !== 16'h00A5) begin bad++; $display("FAIL io_switches got=%h exp=00a5", d1_data); end
      Mem_OE = 1'b0;
      cyc();
   endtask

   task automatic test_abort();
      Mem_WE = 1'b1; ADDR = 16'h0030; Din = 16'h1111;
      cyc();
      cyc();
      Mem_WE = 1'b0;
      cyc();
      Mem_WE = 1'b1; Din = 16'h5555;
      cyc();
      Mem_WE = 1'b0;
      cyc();
      total++;
      if (d1_err !== 1'b1) begin bad++; $display("FAIL abort_err got=%b exp=1", d1_err); end
      total++;
      if (d1_ready !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b exp=0", d1_ready); end
      total++;
      if (d1_data !== 16'h00A5) begin bad++; $display("FAIL abort_data got=%h exp=00a5", d1_data); end
      cyc();
      total++;
      if (d1_err !== 1'b0) begin bad++; $display("FAIL abort_err_pulse got=%b exp=0", d1_err); end
      Mem_OE = 1'b1;
      cyc();
      total++;
      if (d1_data !== 16'h1111) begin bad++; $display("FAIL abort_ram got=%h exp=1111", d1_data); end
      Mem_OE = 1'b0;
      cyc();
   endtask

   task automatic test_both();
      Mem_OE = 1'b1; Mem_WE = 1'b1; ADDR = 16'h0020; Din = 16'hCAFE;
      cyc();
      total++;
      if (d1_err !== 1'b1) begin bad++; $display("FAIL both_err got=%b exp=1", d1_err); end
      Mem_OE = 1'b0;
      cyc();
      total++;
      if (d1_err !== 1'b0) begin bad++; $display("FAIL both_err_pulse got=%b exp=0", d1_err); end
      total++;
      if (d1_ready !== 1'b1) begin bad++; $display("FAIL both_ready got=%b exp=1", d1_ready); end
      Mem_WE = 1'b0;
      cyc();
      Mem_OE = 1'b1;
      cyc();
      total++;
      if (d1_data !== 16'hCAFE) begin bad++; $display("FAIL both_rd got=%h exp=cafe", d1_data); end
      Mem_OE = 1'b0;
      cyc();
   endtask

   task automatic test_rdlat3();
      Mem_OE = 1'b1; ADDR = 16'h0010;
      cyc();
      total++;
      if (d2_ready !== 1'b0) begin bad++; $display("FAIL lat3_c2_ready got=%b exp=0", d2_ready); end
      cyc();
      total++;
      if (d2_ready !== 1'b0) begin bad++; $display("FAIL lat3_c3_ready got=%b exp=0", d2_ready); end
      total++;
      if (d2_data !== 16'h0000) begin bad++; $display("FAIL lat3_c3_data got=%h exp=0000", d2_data); end
      cyc();
      total++;
      if (d2_ready !== 1'b1) begin bad++; $display("FAIL lat3_c4_ready got=%b exp=1", d2_ready); end
      total++;
      if (d2_data !== 16'hBEEF) begin bad++; $display("FAIL lat3_c4_data got=%h exp=beef", d2_data); end
      Mem_OE = 1'b0;
      cyc();
   endtask

   task automatic test_reset_mid();
      Mem_OE = 1'b1; ADDR = 16'h0020;
      cyc();
      #1 Reset = 1'b1;
      #1;
      total++;
      if (d2_data !== 16'h0000) begin bad++; $display("FAIL rst_mid_data got=%h exp=0000", d2_data); end
      total++;
      if (d2_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_ready got=%b exp=0", d2_ready); end
      total++;
      if (d1_hex !== 16'h0000) begin bad++; $display("FAIL rst_mid_hex got=%h exp=0000", d1_hex); end
      total++;
      if (d1_data !== 16'h0000) begin bad++; $display("FAIL rst_mid_d1data got=%h exp=0000", d1_data); end
      #1 Reset = 1'b0;
      Mem_OE = 1'b0;
      cyc();
      Mem_OE = 1'b1;
      cyc();
      total++;
      if (d1_data !== 16'hCAFE) begin bad++; $display("FAIL rst_next_d1 got=%h exp=cafe", d1_data); end
      cyc();
      cyc();
      total++;
      if (d2_data !== 16'hCAFE) begin bad++; $display("FAIL rst_next_d2 got=%h exp=cafe", d2_data); end
      total++;
      if (d2_ready !== 1'b1) begin bad++; $display("FAIL rst_next_ready got=%b exp=1", d2_ready); end
      Mem_OE = 1'b0;
      cyc();
   endtask

   task automatic test_unmapped();
      Mem_WE = 1'b1; ADDR = 16'h1005; Din = 16'h7777;
      cyc();
      cyc();
      total++;
      if (d1_ready !== 1'b1) begin bad++; $display("FAIL unmap_wr_ready got=%b exp=1", d1_ready); end
      Mem_WE = 1'b0;
      cyc();
      Mem_OE = 1'b1;
      cyc();
      total++;
      if (d1_data !== 16'h0000) begin bad++; $display("FAIL unmap_rd got=%h exp=0000", d1_data); end
      total++;
      if (d1_hex !== 16'h0000) begin bad++; $display("FAIL unmap_hex got=%h exp=0000", d1_hex); end
      Mem_OE = 1'b0;
      cyc();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_io();
      test_abort();
      test_both();
      test_rdlat3();
      test_reset_mid();
      test_unmapped();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
